fetch_pc_unit: RTL

//  Front-end fetch stage upstream of decode/branch resolution. Owns the fetch PC and

---
 rtl/fetch_pc_unit.sv | 117 +++++++++++
 1 files changed

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC owner: one outstanding instruction-memory request, a small
// instruction buffer toward decode, and redirect handling with stale-response drop.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  localparam int                PTR_W      = $clog2(BUF_DEPTH);
  localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W + 1)'(BUF_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DROP
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [31:0]       fetch_pc;
  logic [31:0]       req_pc;
  logic [31:0]       redirect_target;
  logic [31:0]       buf_pc    [BUF_DEPTH];
  logic [31:0]       buf_instr [BUF_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W:0]    count;
  logic              handshake;
  logic              push;
  logic              pop;
  logic              unused_bits;

  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign unused_bits     = ^redirect_pc[1:0];

  // Request issue depends only on registered state so a raised valid stays stable.
  assign imem_req_valid = (state == S_IDLE) && (count < FULL_COUNT) && !rst;
  assign imem_req_addr  = fetch_pc;
  assign handshake      = imem_req_valid && imem_req_ready;

  assign push = (state == S_WAIT) && imem_resp_valid && !redirect_valid;
  assign pop  = out_valid && out_ready && !redirect_valid;

  assign out_valid = (count != '0) && !rst;
  assign out_pc    = buf_pc[rd_ptr];
  assign out_instr = buf_instr[rd_ptr];

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (handshake) state_nxt = redirect_valid ? S_DROP : S_WAIT;
      S_WAIT: begin
        if (imem_resp_valid)     state_nxt = S_IDLE;
        else if (redirect_valid) state_nxt = S_DROP;
      end
      S_DROP: if (imem_resp_valid) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      state <= state_nxt;
      if (handshake) req_pc <= fetch_pc;

      if (redirect_valid)  fetch_pc <= redirect_target;
      else if (handshake)  fetch_pc <= fetch_pc + 32'd4;

      // A redirect flushes the buffer; same-cycle push/pop are already masked.
      if (redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: buffer storage is not reset; count gates every read, so stale
  // contents are never visible and the array can map to plain registers/RAM.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      buf_pc[wr_ptr]    <= req_pc;
      buf_instr[wr_ptr] <= imem_resp_data;
    end
  end

endmodule
